// File: rtl/spi_pkg.sv
// Purpose: shared constants for the SPI byte receiver and its downstream consumers.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: default word width, default synchroniser depth, and the frame header byte.
package spi_pkg;

  localparam int         SPI_BYTE_W      = 8;
  localparam int         SPI_SYNC_STAGES = 2;
  // Header byte that opens a frame for the dispenser; the receiver itself does not decode it.
  localparam logic [7:0] SPI_SYNC_CHAR   = 8'h55;

endpackage

// File: rtl/spi_in_sync.sv
// Purpose: N-stage synchroniser for one asynchronous input, with rise/fall detection.
// Latency: STAGES clk edges from input change to q_o; rise_o/fall_o are valid alongside q_o.
// Backpressure: none; free-running.
// Ports:
//   clk, rst_n - system clock, async active-low reset (all flops load RST_VAL)
//   d_i        - asynchronous input
//   q_o        - synchronised level (last stage)
//   rise_o     - q_o went 0->1 at the last clk edge (combinational, one cycle)
//   fall_o     - q_o went 1->0 at the last clk edge (combinational, one cycle)
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Resetting every stage to the idle level keeps the edge detector quiet
  // when reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_rx_byte_slave.sv
// Purpose: SPI mode-0 slave; deserialises MSB-first words from mosi and shifts tx_byte out on miso.
// Latency: rdy/rx_byte update SYNC_STAGES+1 clk edges after the last sclk rise is first sampled.
// Backpressure: none; rx_byte holds until the next word completes, the consumer must keep pace.
// Ports:
//   clk, reset       - system clock (>= 4x sclk), async active-low reset
//   sclk, mosi, cs_n - asynchronous SPI inputs from the host
//   tx_byte          - word returned to the host, captured at frame start and at each word boundary
//   rx_byte, rdy     - last complete word and its one-cycle update strobe
//   miso, miso_oe    - SPI data out and tristate enable (high while frame is active)
//   frame_err        - one-cycle pulse when cs_n rises with a partial word pending
module spi_rx_byte_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter int BYTE_W      = SPI_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rdy,
  output logic              miso,
  output logic              miso_oe,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s;
  logic cs_s, cs_rise, cs_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (sclk),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Only the level of mosi matters; its edges are not used.
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (),
    .fall_o ()
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (cs_n),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              miso_q, miso_d;
  logic              rdy_q, rdy_d;
  logic              ferr_q, ferr_d;
  logic [BYTE_W-1:0] shift_nxt;

  assign shift_nxt = {shift_q[BYTE_W-2:0], mosi_s};

  always_comb begin
    shift_d   = shift_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    miso_d    = miso_q;
    rdy_d     = 1'b0;
    ferr_d    = 1'b0;

    // cs_n rise outranks any sclk edge seen in the same cycle, so a word
    // cannot complete on the edge that closes the frame.
    if (cs_rise) begin
      bit_cnt_d = '0;
      ferr_d    = (bit_cnt_q != '0);
    end else if (cs_fall) begin
      bit_cnt_d = '0;
      tx_d      = tx_byte;
      miso_d    = tx_byte[BYTE_W-1];
    end else if (!cs_s) begin
      if (sclk_rise) begin
        shift_d = shift_nxt;
        if (bit_cnt_q == LAST_BIT) begin
          rx_d      = shift_nxt;
          rdy_d     = 1'b1;
          bit_cnt_d = '0;
          tx_d      = tx_byte;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else if (sclk_fall) begin
        // A fall with bit_cnt at 0 follows a word boundary: tx_q was just
        // reloaded, so present its MSB rather than advancing.
        if (bit_cnt_q == '0) begin
          miso_d = tx_q[BYTE_W-1];
        end else begin
          miso_d = tx_q[BYTE_W-2];
          tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_byte   = rx_q;
  assign rdy       = rdy_q;
  assign miso      = miso_q;
  assign miso_oe   = ~cs_s;
  assign frame_err = ferr_q;

  // sclk_s level is implied by its edges; kept for waveform readability.
  logic sclk_lvl_unused;
  assign sclk_lvl_unused = sclk_s;

endmodule

// File: tb/tb_spi_rx_byte_slave.sv
// Purpose: self-checking bench for spi_rx_byte_slave with a received-byte scoreboard.
// Latency: checks rdy arrives exactly 3 clk edges after the final sclk rise.
// Backpressure: n/a.
module tb_spi_rx_byte_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       rdy;
  logic       miso;
  logic       miso_oe;
  logic       frame_err;

  spi_rx_byte_slave #(.SYNC_STAGES(2), .BYTE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .tx_byte   (tx_byte),
    .rx_byte   (rx_byte),
    .rdy       (rdy),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         exp_rdy = 0;
  int         rdy_seen = 0;
  int         exp_ferr = 0;
  int         ferr_seen = 0;
  int         cyc = 0;
  int         last_rise_cyc = 0;
  logic [7:0] m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rdy && frame_err) chk("rdy_ferr_excl", {31'b0, frame_err}, 32'd0);
    if (rdy) begin
      rdy_seen++;
      if (exp_q.size() == 0) chk("unexpected_rdy", exp_q.size(), 32'd1);
      else begin
        chk("rx_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
        chk("rdy_latency", cyc - last_rise_cyc, 32'd3);
      end
    end
    if (frame_err) ferr_seen++;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Sends the first n bits of b MSB-first at sclk = clk/8; returns the miso
  // bits the host would sample on each sclk rise.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] miso_seen);
    miso_seen = '0;
    if (n == 8) begin
      exp_q.push_back(b);
      exp_rdy++;
    end
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      clks(4);
      miso_seen = {miso_seen[6:0], miso};
      sclk = 1'b1;
      last_rise_cyc = cyc;
      clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_rdy_count"}, rdy_seen, exp_rdy);
    chk({tag, "_ferr_count"}, ferr_seen, exp_ferr);
    chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] frame [8];
    frame = '{8'h55, 8'h10, 8'h02, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'h01};

    reset = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_byte = 8'h00;
    clks(3);
    chk("rst_rx_byte", {24'b0, rx_byte}, 32'd0);
    chk("rst_rdy", {31'b0, rdy}, 32'd0);
    chk("rst_miso", {31'b0, miso}, 32'd0);
    chk("rst_miso_oe", {31'b0, miso_oe}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    clks(2);
    reset = 1'b1;

    // Idle bus with sclk toggling: nothing must happen.
    for (int i = 0; i < 16; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom_range(0, 1));
      clks(2);
    end
    sclk = 1'b0;
    clks(4);
    chk("idle_rx_byte", {24'b0, rx_byte}, 32'd0);
    chk("idle_miso_oe", {31'b0, miso_oe}, 32'd0);
    check_counts("idle");

    // Single header byte.
    cs_n = 1'b0;
    clks(4);
    chk("frame_miso_oe", {31'b0, miso_oe}, 32'd1);
    spi_bits(8'h55, 8, m);
    clks(6);
    chk("hdr_rx_byte", {24'b0, rx_byte}, 32'h55);
    clks(10);
    chk("hdr_rx_hold", {24'b0, rx_byte}, 32'h55);
    cs_n = 1'b1;
    clks(4);
    chk("end_miso_oe", {31'b0, miso_oe}, 32'd0);
    check_counts("hdr");

    // Eight back-to-back bytes in one frame.
    cs_n = 1'b0;
    clks(4);
    for (int i = 0; i < 8; i++) spi_bits(frame[i], 8, m);
    clks(6);
    cs_n = 1'b1;
    clks(4);
    check_counts("b2b");

    // miso readback of tx_byte.
    tx_byte = 8'hA5;
    clks(2);
    cs_n = 1'b0;
    clks(4);
    spi_bits(8'h3C, 8, m);
    chk("miso_seq", {24'b0, m}, 32'hA5);
    clks(6);
    chk("tx_rx_byte", {24'b0, rx_byte}, 32'h3C);
    cs_n = 1'b1;
    clks(4);
    check_counts("tx");

    // Partial byte aborted by cs_n rise.
    cs_n = 1'b0;
    clks(4);
    spi_bits(8'hF0, 5, m);
    clks(4);
    cs_n = 1'b1;
    exp_ferr++;
    clks(6);
    chk("partial_rx_kept", {24'b0, rx_byte}, 32'h3C);
    check_counts("partial");
    cs_n = 1'b0;
    clks(4);
    spi_bits(8'h81, 8, m);
    clks(6);
    chk("after_err_rx", {24'b0, rx_byte}, 32'h81);
    cs_n = 1'b1;
    clks(4);
    check_counts("recover");

    // Reset mid-byte, then a fresh frame.
    cs_n = 1'b0;
    clks(4);
    spi_bits(8'hC3, 4, m);
    reset = 1'b0;
    cs_n = 1'b1;
    clks(3);
    chk("midrst_rx_byte", {24'b0, rx_byte}, 32'd0);
    reset = 1'b1;
    clks(8);
    check_counts("midrst");
    cs_n = 1'b0;
    clks(4);
    spi_bits(8'hC3, 8, m);
    clks(6);
    chk("post_rst_rx", {24'b0, rx_byte}, 32'hC3);
    cs_n = 1'b1;
    clks(4);
    check_counts("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
